// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the TPU command sequencer: bus widths, the default
// idle instruction, the sequencer FSM state encoding and the FIFO entry layout.
// No ports (package).
// -----------------------------------------------------------------------------
package tpu_pkg;

  localparam int INSTR_W  = 16;
  localparam int RESULT_W = 8;
  localparam int CMD_W    = INSTR_W + 1;
  localparam int CNT_W    = 4;

  localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_t;

  // One FIFO entry: the response-request flag sits above the instruction word.
  typedef struct packed {
    logic               want_rsp;
    logic [INSTR_W-1:0] instr;
  } cmd_t;

endpackage

// File: rtl/tpu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// tpu_cmd_fifo
// Synchronous first-word-fall-through command FIFO. Pointers carry one extra
// bit so full and empty are distinguished without a separate counter.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset (flushes pointers)
//   i_push   - write i_data (ignored when full)
//   i_data   - entry to write
//   i_pop    - advance read pointer (ignored when empty)
//   o_data   - head entry (valid when !o_empty)
//   o_full   - no free entries
//   o_empty  - no entries
// -----------------------------------------------------------------------------
module tpu_cmd_fifo
  import tpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data    = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is data only; a flush just moves the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/tpu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tpu_cmd_sequencer
// Accepts host commands into a FIFO, drives each instruction word onto the TPU
// input pins for exactly one cycle, and for commands that expect a result,
// waits RESULT_LAT cycles, captures the TPU output byte and holds it until the
// host takes it.
// Optional build macro: TPU_SEQ_STATS_EN adds issue_count / result_count.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   cmd_valid    - host offers a command
//   cmd_ready    - FIFO has room (= !full)
//   cmd_instr    - instruction word ([7:0] ui_in, [15:8] uio_in)
//   cmd_expect   - command returns one result byte
//   tpu_instr    - registered instruction bus to the TPU
//   tpu_result   - TPU result bus (uo_out)
//   rsp_valid    - captured result available
//   rsp_ready    - host consumes result
//   rsp_data     - captured result byte
//   busy         - FIFO non-empty or FSM not idle
//   issue_count  - (TPU_SEQ_STATS_EN) ISSUE cycles, wraps at 256
//   result_count - (TPU_SEQ_STATS_EN) response handshakes, wraps at 256
// -----------------------------------------------------------------------------
module tpu_cmd_sequencer
  import tpu_pkg::*;
#(
  parameter int                 FIFO_DEPTH = 4,
  parameter int                 RESULT_LAT = 2,
  parameter logic [INSTR_W-1:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [INSTR_W-1:0]  cmd_instr,
  input  logic                cmd_expect,
  output logic [INSTR_W-1:0]  tpu_instr,
  input  logic [RESULT_W-1:0] tpu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [RESULT_W-1:0] rsp_data,
  output logic                busy
`ifdef TPU_SEQ_STATS_EN
  ,
  output logic [7:0]          issue_count,
  output logic [7:0]          result_count
`endif
);

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RESULT_LAT - 1);

  seq_state_t          r_state;
  logic [INSTR_W-1:0]  r_tpu_instr;
  logic                r_want_rsp;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rsp_valid;
  logic [RESULT_W-1:0] r_rsp_data;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [CMD_W-1:0]    w_cmd_in;
  cmd_t                w_head;

  assign w_cmd_in = {cmd_expect, cmd_instr};
  assign w_push   = cmd_valid && !w_full;
  // Pop is decided from registered state only, so a freshly pushed entry is
  // first seen one cycle after its push.
  assign w_pop    = (r_state == ST_IDLE) && !w_empty;

  tpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tpu_instr <= NOP_WORD;
      r_want_rsp  <= 1'b0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_tpu_instr <= w_head.instr;
            r_want_rsp  <= w_head.want_rsp;
            r_state     <= ST_ISSUE;
          end else begin
            r_tpu_instr <= NOP_WORD;
          end
        end
        ST_ISSUE: begin
          r_tpu_instr <= NOP_WORD;
          r_cnt       <= '0;
          r_state     <= r_want_rsp ? ST_WAIT : ST_IDLE;
        end
        ST_WAIT: begin
          // Last WAIT cycle is the only one that looks at tpu_result.
          if (r_cnt == LAT_LAST) begin
            r_rsp_data  <= tpu_result;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef TPU_SEQ_STATS_EN
  logic [7:0] r_issue_count;
  logic [7:0] r_result_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_count  <= '0;
      r_result_count <= '0;
    end else begin
      if (r_state == ST_ISSUE)             r_issue_count  <= r_issue_count + 1'b1;
      if (r_state == ST_RESP && rsp_ready) r_result_count <= r_result_count + 1'b1;
    end
  end

  assign issue_count  = r_issue_count;
  assign result_count = r_result_count;
`endif

  assign cmd_ready = !w_full;
  assign tpu_instr = r_tpu_instr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = !w_empty || (r_state != ST_IDLE);

endmodule

// File: doc/tpu_cmd_sequencer.md
TPU_CMD_SEQUENCER -- requirements
Module: tpu_cmd_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command FIFO entries (power of two, >=2).
REQ-002 Parameter RESULT_LAT, default 2: cycles from instruction drive to valid tpu_result (1..15).
REQ-003 Parameter NOP_WORD, default 16'h0000: instruction driven when idle.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  host command offered.
REQ-007 cmd_ready  out  1  sequencer accepts command.
REQ-008 cmd_instr  in  16  instruction word, [7:0] to ui_in pins, [15:8] to uio_in pins.
REQ-009 cmd_expect  in  1  command returns one result byte.
REQ-010 tpu_instr  out  16  registered instruction bus to TPU.
REQ-011 tpu_result  in  8  TPU result bus (uo_out).
REQ-012 rsp_valid  out  1  result byte available.
REQ-013 rsp_ready  in  1  host consumes result.
REQ-014 rsp_data  out  8  captured result byte.
REQ-015 busy  out  1  high when FIFO non-empty or state != IDLE.

Function
REQ-016 Command accepted on cycle with cmd_valid && cmd_ready; {cmd_expect, cmd_instr} pushed into FIFO.
REQ-017 cmd_ready SHALL equal !full; a push when full is not accepted even if a pop occurs the same cycle.
REQ-018 No bypass: a command pushed into an empty FIFO becomes poppable the following cycle.
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: if FIFO non-empty, pop head -> ISSUE; else stay, tpu_instr = NOP_WORD.
REQ-021 ISSUE (exactly 1 cycle): tpu_instr = popped word; next WAIT if expect else IDLE.
REQ-022 WAIT: tpu_instr = NOP_WORD; counter counts RESULT_LAT cycles after ISSUE cycle; on expiry sample tpu_result into rsp_data, assert rsp_valid, -> RESP.
REQ-023 RESP: rsp_valid, rsp_data held stable until rsp_ready; on handshake rsp_valid deasserts next cycle, -> IDLE.
REQ-024 Latency: command accepted cycle T into empty idle sequencer -> tpu_instr = word during T+2; with expect, rsp_valid rises at T+3+RESULT_LAT.
REQ-025 Commands without expect issue back-to-back every 2 cycles (IDLE, ISSUE); FIFO pushes continue during WAIT/RESP.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH; full/empty via extra pointer bit.
REQ-027 tpu_result is ignored in all states except the WAIT expiry cycle.

Reset
REQ-028 On rst: state IDLE, FIFO flushed (empty), tpu_instr = NOP_WORD, rsp_valid = 0, rsp_data = 8'h00, cmd_ready = 1, busy = 0, counters 0.
REQ-029 Reset mid-operation (any state) discards in-flight command and pending result; no response is produced for it.
REQ-030 cmd_valid asserted during rst is not accepted.

Configuration
REQ-031 Macro TPU_SEQ_STATS_EN: when defined, adds outputs issue_count[7:0] (increments each ISSUE cycle) and result_count[7:0] (increments each rsp handshake), both wrap 255->0, reset to 0.
REQ-032 Without TPU_SEQ_STATS_EN, those ports and counters do not exist; all other behaviour identical.

Structure
REQ-033 Shared package tpu_pkg holds FSM state enumeration, INSTR_W=16, RESULT_W=8, default NOP_WORD constant.
REQ-034 One sub-module tpu_cmd_fifo (synchronous FIFO, width 17, depth FIFO_DEPTH); FSM and capture logic in top.

Verification
REQ-035 Single expect command 16'hA55A, tpu_result model returns 8'h3C RESULT_LAT after -> tpu_instr=16'hA55A at T+2, rsp_valid at T+5, rsp_data=8'h3C.
REQ-036 Push 5 no-expect commands with rsp side idle -> cmd_ready low after 4 accepted until first pop; all 5 words appear on tpu_instr in order, NOP_WORD between.
REQ-037 Expect command with rsp_ready held low 10 cycles -> rsp_data stable, no further issue, then one handshake and next command issues.
REQ-038 Assert rst during WAIT with 2 commands queued -> next cycle tpu_instr=16'h0000, rsp_valid=0, busy=0, no response ever appears.
REQ-039 With TPU_SEQ_STATS_EN, issue 257 no-expect commands -> issue_count=8'h01, result_count=8'h00.
REQ-040 Simultaneous push and pop on full FIFO -> push rejected (cmd_ready=0), occupancy drops by one.
